// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter slice.
// Holds the data width, the register-index width, the skid-buffer entry
// record, the write-source selector enum and a helper that turns a register
// index into a one-hot pending-mask bit. x0 never gets a bit.
package wb_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_W-1:0] reg_idx_t;

    // One buffered load response: where it goes and what it carries.
    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } skid_entry_t;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_EX   = 2'd1,
        WB_SRC_LOAD = 2'd2
    } wb_src_e;

    // One-hot mask bit for a destination register; x0 is hardwired to zero,
    // so it never occupies a pending bit.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (idx != '0) begin
            mask[idx] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_rd_fifo.sv
// Synchronous FIFO holding the destination registers of outstanding loads in
// issue order.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push_i, data_i  enqueue (ignored while full)
//   pop_i           dequeue (ignored while empty)
//   data_o          head entry (valid while !empty_o)
//   count_o         number of stored entries
//   full_o, empty_o occupancy flags
module wb_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and count update. Pointers wrap explicitly so the FIFO stays
    // correct even if the depth is not a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle EX/MEM results and out-of-band load
// responses onto one register-file write port.
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   ex_valid_i/ex_rd_i/ex_data_i EX result this cycle
//   ex_csr_i/csr_data_i          write the CSR old value instead of ex_data
//   ld_issue_i/ld_issue_rd_i     load issued to memory; issue_ready_o accepts
//   ld_valid_i/ld_data_i         load response (issue order); ld_ready_o accepts
//   rf_we_o/rf_waddr_o/rf_wdata_o registered register-file write port
//   pending_o                    bit i set while a load to xi is in flight
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LDQ_DEPTH = 2,
    parameter int XLEN      = wb_arbiter_pkg::XLEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid_i,
    input  logic [REG_W-1:0]    ex_rd_i,
    input  logic [XLEN-1:0]     ex_data_i,
    input  logic                ex_csr_i,
    input  logic [XLEN-1:0]     csr_data_i,
    input  logic                ld_issue_i,
    input  logic [REG_W-1:0]    ld_issue_rd_i,
    output logic                issue_ready_o,
    input  logic                ld_valid_i,
    input  logic [XLEN-1:0]     ld_data_i,
    output logic                ld_ready_o,
    output logic                rf_we_o,
    output logic [REG_W-1:0]    rf_waddr_o,
    output logic [XLEN-1:0]     rf_wdata_o,
    output logic [NUM_REGS-1:0] pending_o
);

    logic                       rdq_push;
    logic                       rdq_pop;
    reg_idx_t                   rdq_head;
    logic [$clog2(LDQ_DEPTH+1)-1:0] rdq_count;
    logic                       rdq_full;
    logic                       rdq_empty;

    skid_entry_t                skid_q, skid_d;
    logic                       skid_full_q, skid_full_d;
    logic [NUM_REGS-1:0]        pending_q, pending_d;

    logic                       rf_we_q, rf_we_d;
    reg_idx_t                   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]            rf_wdata_q, rf_wdata_d;

    logic                       ex_sel;
    logic                       drain_now;
    wb_src_e                    wb_src;

    wb_rd_fifo #(
        .DEPTH (LDQ_DEPTH),
        .WIDTH (REG_W)
    ) u_rdq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rdq_push),
        .data_i  (ld_issue_rd_i),
        .pop_i   (rdq_pop),
        .data_o  (rdq_head),
        .count_o (rdq_count),
        .full_o  (rdq_full),
        .empty_o (rdq_empty)
    );

    // A second load to a register that is still in flight is refused so the
    // pending mask stays a simple set of bits.
    assign issue_ready_o = !rdq_full && !pending_q[ld_issue_rd_i];
    assign rdq_push      = ld_issue_i && issue_ready_o;

    // EX writes to x0 are no-ops and must not stall the skid buffer.
    assign ex_sel    = ex_valid_i && (ex_rd_i != '0);
    assign drain_now = skid_full_q && !ex_sel;

    // The skid can refill in the same cycle it drains. A response with no
    // outstanding load is a protocol violation and is simply not accepted.
    assign ld_ready_o = !rdq_empty && (!skid_full_q || drain_now);
    assign rdq_pop    = ld_valid_i && ld_ready_o;

    // Source selection: EX always wins, otherwise a buffered load drains.
    always_comb begin
        wb_src = WB_SRC_NONE;
        if (ex_sel) begin
            wb_src = WB_SRC_EX;
        end else if (skid_full_q) begin
            wb_src = WB_SRC_LOAD;
        end
    end

    // Next value of the registered write port. A drained load to x0 frees
    // its skid entry but produces no write.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        unique case (wb_src)
            WB_SRC_EX: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = ex_rd_i;
                rf_wdata_d = ex_csr_i ? csr_data_i : ex_data_i;
            end
            WB_SRC_LOAD: begin
                rf_we_d    = (skid_q.rd != '0);
                rf_waddr_d = skid_q.rd;
                rf_wdata_d = skid_q.data;
            end
            default: begin
            end
        endcase
    end

    // Skid buffer and pending mask. A pushed rd can never equal the draining
    // rd (that rd is still pending), so set and clear never collide.
    always_comb begin
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        pending_d   = pending_q;
        if (drain_now) begin
            skid_full_d = 1'b0;
            pending_d   = pending_d & ~reg_onehot(skid_q.rd);
        end
        if (rdq_pop) begin
            skid_full_d = 1'b1;
            skid_d.rd   = rdq_head;
            skid_d.data = ld_data_i;
        end
        if (rdq_push) begin
            pending_d = pending_d | reg_onehot(ld_issue_rd_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            pending_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            pending_q   <= pending_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign pending_o  = pending_q;

endmodule
